pxl_color_proc: RTL
===================

# pxl_color_proc

Pixel colour-processing stage on the VGA read path, clocked by `wclk`. It sits between the frame-buffer read port and the VGA display stage. It takes 16-bit buffer pixels (red 5 / green 5 / blue 6) together with their display sideband and applies one of four user-selected transforms: passthrough, grayscale, binary threshold, or invert. The output has a fixed 3-cycle latency. The mode is cycled by a debounced push button, and a mode change takes effect only at a frame boundary, so no frame is ever drawn in two modes.

## Interface
- `NB_R`, 5, red field width, buffer bits [15:11]
- `NB_G`, 5, green field width, buffer bits [10:6]
- `NB_B`, 6, blue field width, buffer bits [5:0]
- `SB_W`, 3, sideband width (visible, hsync, vsync), delayed with the pixel
- `DEBOUNCE_CYC`, 1_000_000, stable cycles required before a button level is accepted (20 ms at 50 MHz)
- `THRESH`, 32, binary-mode luma threshold, 6-bit scale

Ports:
- `wclk` in 1: 50 MHz clock, all logic on its rising edge
- `rst` in 1: synchronous, active-high reset
- `btn` in 1: raw, asynchronous mode button
- `frame_start` in 1: one-cycle pulse at the start of each frame
- `in_valid` in 1: `in_pxl` / `in_sb` valid this cycle
- `in_pxl` in 16: buffer pixel
- `in_sb` in `SB_W`: sideband aligned with `in_pxl`
- `out_valid` out 1: `in_valid` delayed 3 cycles
- `out_pxl` out 16: processed pixel
- `out_sb` out `SB_W`: `in_sb` delayed 3 cycles
- `mode` out 2: active mode (0 pass, 1 gray, 2 binary, 3 invert)

## Operation
- Button path:
  - 2-FF synchronizer, then debounce.
  - The counter resets whenever the synchronized level differs from the debounced level.
  - When the counter reaches `DEBOUNCE_CYC-1`, the debounced level takes the synchronized level.
  - A rising edge of the debounced level increments `pending`, wrapping 3→0.
- Mode commit:
  - On `frame_start`, `mode <= pending`.
  - If a press edge and `frame_start` fall in the same cycle, `mode` takes the old `pending`. The new value commits at the next `frame_start`.
- Pixel pipeline (no stall; the display never back-pressures):
  - Stage 1: register the pixel and sideband. Expand channels to 6 bits: `r6={r5,r5[4]}`, `g6={g5,g5[4]}`, `b6=b`.
  - Stage 2: compute the 9-bit sum `Y9 = 2*r6 + 5*g6 + b6` (max 504). Then `Y = Y9[8:3]`, 6 bits, max 63.
  - Stage 3: output mux selected by the `mode` value sampled at stage 1 (the mode is carried down the pipe).
    - pass: the pixel unchanged.
    - gray: `{Y[5:1], Y[5:1], Y}`.
    - binary: 0xFFFF if `Y >= THRESH`, else 0x0000.
    - invert: `~pxl`.
- Data registers advance every cycle regardless of `in_valid`. `out_pxl` and `out_sb` are don't-care when `out_valid=0`, but they remain deterministic.

## Timing
- Latency: input at cycle N appears at `out_*` at N+3. Throughput is one pixel per cycle.
- `mode` updates the cycle after `frame_start`. Pixels already in flight keep the mode they entered with.
- Button: from a stable level change at the `btn` pin, the debounced edge occurs after 2 (sync) + `DEBOUNCE_CYC` cycles. `pending` updates one cycle later.
- Glitches shorter than `DEBOUNCE_CYC` cycles produce no edge.
- Reset values:
  - `out_valid=0`, `out_pxl=0`, `out_sb=0`
  - `mode=0`, `pending=0`
  - debounced level 0, counter 0, synchronizer 0
  - all pipeline valid bits 0
- Reset asserted mid-frame: the pipeline flushes. The first `out_valid` after reset release comes 3 cycles after the first `in_valid`.

## Structure
- Package `color_proc_pkg`:
  - mode localparams `MODE_PASS=0`, `MODE_GRAY=1`, `MODE_BIN=2`, `MODE_INV=3`
  - channel field bit positions
  - luma weights (2, 5, 1) and shift (3)
- Sub-module `btn_debounce`: synchronizer, counter, debounced level and a one-cycle `rise` pulse, parameterised by `DEBOUNCE_CYC`. It is reused for the other board buttons.

## Test plan
All scenarios use `DEBOUNCE_CYC=4`.
- Reset, then mode 0 with `in_pxl=0xF800` and `in_sb=3'b101` at cycle N → `out_pxl=0xF800`, `out_sb=3'b101`, `out_valid=1` at N+3, and `out_valid=0` at N+2 and N+4.
- Gray mode:
  - 0xF800 → 0x39CF
  - 0xFFFF → 0xFFFF
  - 0x0000 → 0x0000
  - back-to-back inputs every cycle, checked against the luma model
- Binary mode with `THRESH=32`: 0xF800 (Y=15) → 0x0000, and 0xFFFF → 0xFFFF. Invert mode: 0xF800 → 0x07FF.
- Debounce and commit:
  - A 3-cycle `btn` pulse leaves `pending` unchanged.
  - A held press sets `pending=1`, while `mode` stays 0 until `frame_start`, then becomes 1.
  - Four presses wrap `pending` back to 0.
- Press edge coincident with `frame_start` → `mode` takes the prior `pending` value. The new value applies at the next `frame_start`.
- `rst` asserted with 3 pixels in flight → no `out_valid` during or after reset until new input. `mode=0`, `pending=0`.

Source files
------------

// File: rtl/color_proc_pkg.sv
// -----------------------------------------------------------------------------
// color_proc_pkg
// Shared constants and helpers for the pixel colour-processing stage:
//   - display mode encodings
//   - RGB565-style field positions in the 16-bit frame-buffer word (5/5/6)
//   - luma weights and normalising shift
//   - channel expansion and luma helper functions
// -----------------------------------------------------------------------------
package color_proc_pkg;

   localparam logic [1:0] MODE_PASS = 2'd0;
   localparam logic [1:0] MODE_GRAY = 2'd1;
   localparam logic [1:0] MODE_BIN  = 2'd2;
   localparam logic [1:0] MODE_INV  = 2'd3;

   // Field LSB positions inside the buffer word: R[15:11] G[10:6] B[5:0]
   localparam int R_LSB = 11;
   localparam int G_LSB = 6;
   localparam int B_LSB = 0;

   // Y9 = 2*r6 + 5*g6 + 1*b6, max 504; Y = Y9 >> 3 gives a 6-bit luma
   localparam int LUMA_WR    = 2;
   localparam int LUMA_WG    = 5;
   localparam int LUMA_WB    = 1;
   localparam int LUMA_SHIFT = 3;

   // Replicating the MSB maps 0..31 onto 0..63 with both endpoints exact
   function automatic logic [5:0] expand5(input logic [4:0] c);
      return {c, c[4]};
   endfunction

   function automatic logic [5:0] luma6(input logic [5:0] r6,
                                        input logic [5:0] g6,
                                        input logic [5:0] b6);
      logic [8:0] y9;
      y9 = 9'(LUMA_WR) * {3'b000, r6}
         + 9'(LUMA_WG) * {3'b000, g6}
         + 9'(LUMA_WB) * {3'b000, b6};
      return y9[LUMA_SHIFT +: 6];
   endfunction

endpackage

// File: rtl/pxl_color_proc_btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Two-flop synchronizer followed by a level debouncer. The accepted level only
// follows the synchronized input once it has differed from it for
// DEBOUNCE_CYC consecutive cycles. o_rise pulses for one cycle, coincident
// with the accepted level going high.
// Ports:
//   wclk    in  clock
//   rst     in  synchronous active-high reset
//   i_btn   in  raw asynchronous button
//   o_level out debounced level
//   o_rise  out one-cycle pulse on debounced rising edge
// -----------------------------------------------------------------------------
module btn_debounce #(
   parameter int DEBOUNCE_CYC = 1_000_000
) (
   input  logic wclk,
   input  logic rst,
   input  logic i_btn,
   output logic o_level,
   output logic o_rise
);

   localparam int              CNT_W    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_level;
   logic             r_rise;
   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge wclk) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_level <= 1'b0;
         r_rise  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
         r_rise  <= 1'b0;
         // Any return to the accepted level restarts the stability window
         if (r_sync2 == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_LAST) begin
            r_level <= r_sync2;
            r_rise  <= r_sync2;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_level = r_level;
   assign o_rise  = r_rise;

endmodule

// File: rtl/pxl_color_proc.sv
// -----------------------------------------------------------------------------
// pxl_color_proc
// Colour-processing stage on the VGA read path. Applies passthrough,
// grayscale, binary threshold or invert to 16-bit buffer pixels with a fixed
// three-cycle latency and one pixel per cycle. The mode is stepped by a
// debounced button and committed only on frame_start, so a frame never mixes
// modes; each pixel carries the mode it entered with down the pipe.
// Ports:
//   wclk        in  clock
//   rst         in  synchronous active-high reset
//   btn         in  raw mode button
//   frame_start in  one-cycle pulse at start of frame
//   in_valid    in  input pixel/sideband valid
//   in_pxl      in  buffer pixel R[15:11] G[10:6] B[5:0]
//   in_sb       in  sideband (visible, hsync, vsync)
//   out_valid   out in_valid delayed 3 cycles
//   out_pxl     out processed pixel
//   out_sb      out in_sb delayed 3 cycles
//   mode        out active mode (0 pass, 1 gray, 2 binary, 3 invert)
// -----------------------------------------------------------------------------
module pxl_color_proc
   import color_proc_pkg::*;
#(
   parameter int NB_R         = 5,
   parameter int NB_G         = 5,
   parameter int NB_B         = 6,
   parameter int SB_W         = 3,
   parameter int DEBOUNCE_CYC = 1_000_000,
   parameter int THRESH       = 32
) (
   input  logic            wclk,
   input  logic            rst,
   input  logic            btn,
   input  logic            frame_start,
   input  logic            in_valid,
   input  logic [15:0]     in_pxl,
   input  logic [SB_W-1:0] in_sb,
   output logic            out_valid,
   output logic [15:0]     out_pxl,
   output logic [SB_W-1:0] out_sb,
   output logic [1:0]      mode
);

   localparam logic [5:0] THRESH6 = 6'(THRESH);

   // ---------------------------------------------------------------- button
   logic       w_btn_level;
   logic       w_btn_rise;
   logic [1:0] r_pending;
   logic [1:0] r_mode;

   btn_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
   ) u_btn_debounce (
      .wclk    (wclk),
      .rst     (rst),
      .i_btn   (btn),
      .o_level (w_btn_level),
      .o_rise  (w_btn_rise)
   );

   // The level itself is not needed here; only presses step the mode.
   logic w_unused_level;
   assign w_unused_level = w_btn_level;

   // Non-blocking read of r_pending means a press landing on frame_start
   // commits the previous value; the new one waits for the next frame.
   always_ff @(posedge wclk) begin
      if (rst) begin
         r_pending <= MODE_PASS;
         r_mode    <= MODE_PASS;
      end else begin
         if (w_btn_rise) begin
            r_pending <= r_pending + 2'd1;
         end
         if (frame_start) begin
            r_mode <= r_pending;
         end
      end
   end

   assign mode = r_mode;

   // ------------------------------------------------------- stage 1 (input)
   logic [NB_R-1:0] w_r5;
   logic [NB_G-1:0] w_g5;
   logic [NB_B-1:0] w_b6;

   assign w_r5 = in_pxl[R_LSB +: NB_R];
   assign w_g5 = in_pxl[G_LSB +: NB_G];
   assign w_b6 = in_pxl[B_LSB +: NB_B];

   logic            r1_valid;
   logic [15:0]     r1_pxl;
   logic [SB_W-1:0] r1_sb;
   logic [1:0]      r1_mode;
   logic [5:0]      r1_r6;
   logic [5:0]      r1_g6;
   logic [5:0]      r1_b6;

   always_ff @(posedge wclk) begin
      if (rst) begin
         r1_valid <= 1'b0;
         r1_pxl   <= '0;
         r1_sb    <= '0;
         r1_mode  <= MODE_PASS;
         r1_r6    <= '0;
         r1_g6    <= '0;
         r1_b6    <= '0;
      end else begin
         r1_valid <= in_valid;
         r1_pxl   <= in_pxl;
         r1_sb    <= in_sb;
         r1_mode  <= r_mode;
         r1_r6    <= expand5(w_r5);
         r1_g6    <= expand5(w_g5);
         r1_b6    <= w_b6;
      end
   end

   // -------------------------------------------------------- stage 2 (luma)
   logic            r2_valid;
   logic [15:0]     r2_pxl;
   logic [SB_W-1:0] r2_sb;
   logic [1:0]      r2_mode;
   logic [5:0]      r2_y;

   always_ff @(posedge wclk) begin
      if (rst) begin
         r2_valid <= 1'b0;
         r2_pxl   <= '0;
         r2_sb    <= '0;
         r2_mode  <= MODE_PASS;
         r2_y     <= '0;
      end else begin
         r2_valid <= r1_valid;
         r2_pxl   <= r1_pxl;
         r2_sb    <= r1_sb;
         r2_mode  <= r1_mode;
         r2_y     <= luma6(r1_r6, r1_g6, r1_b6);
      end
   end

   // --------------------------------------------------------- stage 3 (mux)
   logic            r3_valid;
   logic [15:0]     r3_pxl;
   logic [SB_W-1:0] r3_sb;

   always_ff @(posedge wclk) begin
      if (rst) begin
         r3_valid <= 1'b0;
         r3_pxl   <= '0;
         r3_sb    <= '0;
      end else begin
         r3_valid <= r2_valid;
         r3_sb    <= r2_sb;
         case (r2_mode)
            MODE_PASS: r3_pxl <= r2_pxl;
            // 5-bit luma in R and G fields, full 6-bit luma in B
            MODE_GRAY: r3_pxl <= {r2_y[5:1], r2_y[5:1], r2_y};
            MODE_BIN:  r3_pxl <= (r2_y >= THRESH6) ? 16'hFFFF : 16'h0000;
            default:   r3_pxl <= ~r2_pxl;
         endcase
      end
   end

   assign out_valid = r3_valid;
   assign out_pxl   = r3_pxl;
   assign out_sb    = r3_sb;

endmodule
